jtag_master: RTL and testbench



---
 rtl/jtag_master_pkg.sv | 56 +++++
 rtl/jtag_master.sv | 204 ++++++++++++++++++++
 tb/tb_jtag_master.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - command, state and TMS-sequence definitions for the JTAG initiator
//
// Purpose: encodings shared by jtag_master: command types, controller states,
// TMS prefix/postfix lengths and the prefix TMS pattern per command.
// Ports: none (package).

package jtag_master_pkg;

  localparam logic [1:0] CMD_RESET = 2'd0;
  localparam logic [1:0] CMD_IR    = 2'd1;
  localparam logic [1:0] CMD_DR    = 2'd2;

  typedef enum logic [2:0] {
    ST_POR_TLR,
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RESP
  } state_t;

  // TCK cycles spent walking the TAP into Shift-xR (or into Test-Logic-Reset).
  localparam int PRE_DR  = 3;
  localparam int PRE_IR  = 4;
  localparam int PRE_RST = 5;

  // Scans leave through Exit1 -> Update -> Idle and spend one extra TCK in
  // Run-Test/Idle; a reset only needs the single step from TLR into Idle.
  localparam int POST_SCAN = 3;
  localparam int POST_RST  = 1;

  // Power-on walk: five TMS=1 cycles into TLR, one TMS=0 into Run-Test/Idle.
  localparam int POR_LEN = 6;

  function automatic int pre_len(input logic [1:0] typ);
    case (typ)
      CMD_DR:  return PRE_DR;
      CMD_IR:  return PRE_IR;
      default: return PRE_RST;
    endcase
  endfunction

  function automatic int post_len(input logic [1:0] typ);
    return (typ == CMD_RESET) ? POST_RST : POST_SCAN;
  endfunction

  // TMS value for prefix cycle idx: DR 1,0,0 / IR 1,1,0,0 / RESET 1,1,1,1,1.
  function automatic logic pre_tms(input logic [1:0] typ, input int idx);
    case (typ)
      CMD_DR:  return (idx == 0);
      CMD_IR:  return (idx < 2);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - bit-banged IEEE 1149.1 initiator with command/response channels
//
// Purpose: walks a target TAP through IR/DR scans or a reset on request and
// returns the TDO bits captured during the shift.
// Ports:
//   clk_8388, ck_rst        block clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_type, cmd_len (bits-1), cmd_data (LSB first)
//   rsp_valid/rsp_ready     response handshake; rsp_data holds captured TDO, bit 0 first
//   tck_o, tms_o, tdi_o     JTAG pins driven to the target
//   tdo_i                   JTAG data returned from the target

module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LW      = $clog2(MAX_LEN)
) (
  input  logic               clk_8388,
  input  logic               ck_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LW-1:0]      cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  state_t               state_q, state_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        cnt_inc;
  logic                 tck_q, tck_d;
  logic                 tms_q, tms_d;
  logic                 tdi_q, tdi_d;
  logic [1:0]           typ_q, typ_d;
  logic [LW-1:0]        len_q, len_d;
  logic [MAX_LEN-1:0]   sdata_q, sdata_d;
  logic [MAX_LEN-1:0]   cap_q, cap_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0]   rsp_data_q, rsp_data_d;

  // The single phase/bit counter wraps at LW bits, so a full MAX_LEN scan
  // ends on cnt_q == MAX_LEN-1 without needing a wider compare.
  assign cnt_inc = cnt_q + LW'(1);

  assign tck_o     = tck_q;
  assign tms_o     = tms_q;
  assign tdi_o     = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;

  always_ff @(posedge clk_8388 or negedge ck_rst) begin
    if (!ck_rst) begin
      state_q     <= ST_POR_TLR;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      typ_q       <= CMD_RESET;
      len_q       <= '0;
      sdata_q     <= '0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      typ_q       <= typ_d;
      len_q       <= len_d;
      sdata_q     <= sdata_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // While a sequence runs, tck toggles every clk. An edge with tck_q=1 drives
  // TCK low and is where TMS/TDI advance; an edge with tck_q=0 drives TCK high
  // and is where TDO is captured.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    typ_d       = typ_q;
    len_d       = len_q;
    sdata_d     = sdata_q;
    cap_d       = cap_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_POR_TLR: begin
        tck_d = ~tck_q;
        if (tck_q) begin
          if (cnt_q == LW'(POR_LEN - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tms_d   = 1'b0;
          end else begin
            cnt_d = cnt_inc;
            tms_d = (cnt_q != LW'(POR_LEN - 2));
          end
        end
      end

      ST_IDLE: begin
        tck_d = 1'b0;
        tms_d = 1'b0;
        if (cmd_valid && !rsp_valid_q) begin
          // Reserved encoding behaves as RESET.
          typ_d   = (cmd_type == CMD_IR || cmd_type == CMD_DR) ? cmd_type : CMD_RESET;
          len_d   = cmd_len;
          sdata_d = cmd_data;
          cap_d   = '0;
          cnt_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          state_d = ST_PRE;
        end
      end

      ST_PRE: begin
        tck_d = ~tck_q;
        if (tck_q) begin
          if (cnt_q == LW'(pre_len(typ_q) - 1)) begin
            cnt_d = '0;
            if (typ_q == CMD_RESET) begin
              state_d = ST_POST;
              tms_d   = 1'b0;
            end else begin
              state_d = ST_SHIFT;
              tms_d   = (len_q == '0);
              tdi_d   = sdata_q[0];
            end
          end else begin
            cnt_d = cnt_inc;
            tms_d = pre_tms(typ_q, int'(cnt_inc));
          end
        end
      end

      ST_SHIFT: begin
        tck_d = ~tck_q;
        if (!tck_q) begin
          cap_d[cnt_q] = tdo_i;
        end else if (cnt_q == len_q) begin
          state_d = ST_POST;
          cnt_d   = '0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else begin
          cnt_d   = cnt_inc;
          tms_d   = (cnt_inc == len_q);
          tdi_d   = sdata_q[1];
          sdata_d = sdata_q >> 1;
        end
      end

      ST_POST: begin
        tck_d = ~tck_q;
        if (tck_q) begin
          tms_d = 1'b0;
          if (cnt_q == LW'(post_len(typ_q) - 1)) begin
            state_d     = ST_RESP;
            cnt_d       = '0;
            tdi_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      ST_RESP: begin
        tck_d = 1'b0;
        tms_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_POR_TLR;
        cnt_d   = '0;
        tck_d   = 1'b0;
        tms_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - scoreboard bench for jtag_master

module tb_jtag_master;

  localparam int MAX_LEN = 64;
  localparam int LW      = 6;

  logic               clk_8388;
  logic               ck_rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_type;
  logic [LW-1:0]      cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck_o;
  logic               tms_o;
  logic               tdi_o;
  logic               tdo_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accept_cyc;
  int rise_cnt = 0;
  int tdo_mode = 0;
  logic tck_prev = 1'b0;

  logic [MAX_LEN-1:0] exp_q[$];
  logic tms_log[$];
  logic tdi_log[$];

  jtag_master #(.MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk_8388 (clk_8388),
    .ck_rst   (ck_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type (cmd_type),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .tck_o    (tck_o),
    .tms_o    (tms_o),
    .tdi_o    (tdi_o),
    .tdo_i    (tdo_i)
  );

  // Target model: loopback, tied high, or toggling once per TCK rise.
  int rise_par;
  assign rise_par = rise_cnt;
  assign tdo_i = (tdo_mode == 0) ? tdi_o : (tdo_mode == 1) ? 1'b1 : rise_par[0];

  initial clk_8388 = 1'b0;
  always #5 clk_8388 = ~clk_8388;

  always @(posedge clk_8388) cyc <= cyc + 1;

  always @(negedge clk_8388) begin
    if (tck_o && !tck_prev) begin
      tms_log.push_back(tms_o);
      tdi_log.push_back(tdi_o);
      rise_cnt = rise_cnt + 1;
    end
    tck_prev = tck_o;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int typ, input int nbits, output logic [127:0] seq, output int n);
    seq = '0;
    if (typ == 2) begin
      seq[0] = 1'b1; n = 3;
    end else if (typ == 1) begin
      seq[0] = 1'b1; seq[1] = 1'b1; n = 4;
    end else begin
      seq[4:0] = 5'h1f; n = 5;
    end
    if (typ == 1 || typ == 2) begin
      n = n + nbits;
      seq[n-1] = 1'b1;
      seq[n]   = 1'b1;
      n = n + 3;
    end else begin
      n = n + 1;
    end
  endtask

  function automatic logic [MAX_LEN-1:0] model_rsp(input int typ, input int clen,
                                                   input logic [MAX_LEN-1:0] data, input int mode);
    logic [MAX_LEN-1:0] r;
    int pre;
    r = '0;
    if (typ == 1 || typ == 2) begin
      pre = (typ == 2) ? 3 : 4;
      for (int i = 0; i <= clen; i++) begin
        if (mode == 0)      r[i] = data[i];
        else if (mode == 1) r[i] = 1'b1;
        else                r[i] = ((pre + i) % 2) == 1;
      end
    end
    return r;
  endfunction

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    rise_cnt = 0;
  endtask

  task automatic send_cmd(input int typ, input int clen, input logic [MAX_LEN-1:0] data);
    int k;
    cmd_type  = 2'(typ);
    cmd_len   = LW'(clen);
    cmd_data  = data;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 300) begin
      @(negedge clk_8388);
      k++;
    end
    check("cmd_accept", 128'(cmd_ready), 128'(1));
    accept_cyc = cyc + 1;
    clear_logs();
    @(negedge clk_8388);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int typ, input int clen, input logic [MAX_LEN-1:0] data);
    int k;
    int n;
    int pre;
    logic [127:0] seq;
    logic [127:0] obs;
    logic [MAX_LEN-1:0] exp_tdi;
    logic [MAX_LEN-1:0] obs_tdi;
    logic [MAX_LEN-1:0] exp_r;
    build_exp(typ, clen + 1, seq, n);
    k = 0;
    while (!rsp_valid && k < 400) begin
      @(negedge clk_8388);
      k++;
    end
    check({tag, "_rsp_seen"}, 128'(rsp_valid), 128'(1));
    check({tag, "_latency"}, 128'(cyc - accept_cyc), 128'(2 * n));
    check({tag, "_tck_end"}, 128'(tck_o), 128'(0));
    check({tag, "_tms_end"}, 128'(tms_o), 128'(0));
    check({tag, "_rises"}, 128'(tms_log.size()), 128'(n));
    obs = '0;
    for (int i = 0; i < tms_log.size() && i < 128; i++) obs[i] = tms_log[i];
    check({tag, "_tms_seq"}, obs, seq);
    if (typ == 1 || typ == 2) begin
      pre = (typ == 2) ? 3 : 4;
      exp_tdi = '0;
      obs_tdi = '0;
      for (int i = 0; i <= clen; i++) begin
        exp_tdi[i] = data[i];
        if (pre + i < tdi_log.size()) obs_tdi[i] = tdi_log[pre + i];
      end
      check({tag, "_tdi_bits"}, 128'(obs_tdi), 128'(exp_tdi));
    end
    if (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      check({tag, "_rsp_data"}, 128'(rsp_data), 128'(exp_r));
    end else begin
      check({tag, "_sb_underflow"}, 128'(exp_q.size()), 128'(1));
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk_8388);
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input int typ, input int clen,
                        input logic [MAX_LEN-1:0] data, input int mode);
    tdo_mode = mode;
    exp_q.push_back(model_rsp(typ, clen, data, mode));
    send_cmd(typ, clen, data);
    wait_rsp(tag, typ, clen, data);
    take_rsp();
  endtask

  task automatic por_check(input string tag);
    int k;
    int c0;
    logic [127:0] obs;
    clear_logs();
    @(negedge clk_8388);
    ck_rst = 1'b1;
    c0 = cyc;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk_8388);
      k++;
    end
    check({tag, "_ready"}, 128'(cmd_ready), 128'(1));
    check({tag, "_ready_delay"}, 128'(cyc - c0), 128'(12));
    check({tag, "_rises"}, 128'(tms_log.size()), 128'(6));
    obs = '0;
    for (int i = 0; i < tms_log.size() && i < 128; i++) obs[i] = tms_log[i];
    check({tag, "_tms_seq"}, obs, 128'h1f);
  endtask

  initial begin
    logic [MAX_LEN-1:0] d1;
    logic [MAX_LEN-1:0] d2;
    logic [MAX_LEN-1:0] snap;
    int k;
    int bad_ready;
    int bad_data;
    int bad_valid;

    ck_rst    = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = 2'd0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    tdo_mode  = 0;
    repeat (3) @(negedge clk_8388);

    check("rst_tck", 128'(tck_o), 128'(0));
    check("rst_tms", 128'(tms_o), 128'(1));
    check("rst_tdi", 128'(tdi_o), 128'(0));
    check("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data", 128'(rsp_data), 128'(0));

    por_check("por");

    do_cmd("dr8", 2, 7, 64'hA5, 0);
    do_cmd("ir5", 1, 4, 64'h01, 1);
    do_cmd("rst", 0, 0, {$urandom, $urandom}, 0);
    do_cmd("rsv", 3, 5, {$urandom, $urandom}, 0);
    do_cmd("dr64", 2, MAX_LEN - 1, {$urandom, $urandom}, 2);
    do_cmd("dr13", 2, 12, {$urandom, $urandom}, 0);

    // Backpressure with a second command waiting.
    tdo_mode = 0;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    exp_q.push_back(model_rsp(2, 15, d1, 0));
    send_cmd(2, 15, d1);
    cmd_type  = 2'd2;
    cmd_len   = LW'(7);
    cmd_data  = d2;
    cmd_valid = 1'b1;
    wait_rsp("bp1", 2, 15, d1);
    snap = rsp_data;
    bad_ready = 0;
    bad_data  = 0;
    bad_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_8388);
      if (cmd_ready !== 1'b0) bad_ready++;
      if (rsp_data !== snap) bad_data++;
      if (rsp_valid !== 1'b1) bad_valid++;
    end
    check("bp_cmd_ready_low", 128'(bad_ready), 128'(0));
    check("bp_rsp_stable", 128'(bad_data), 128'(0));
    check("bp_rsp_held", 128'(bad_valid), 128'(0));
    exp_q.push_back(model_rsp(2, 7, d2, 0));
    take_rsp();
    check("bp_b2b_ready", 128'(cmd_ready), 128'(1));
    accept_cyc = cyc + 1;
    clear_logs();
    @(negedge clk_8388);
    cmd_valid = 1'b0;
    wait_rsp("bp2", 2, 7, d2);
    take_rsp();

    // Reset in the middle of a 32-bit DR shift.
    tdo_mode = 0;
    send_cmd(2, 31, {$urandom, $urandom});
    k = 0;
    while (rise_cnt < 14 && k < 200) begin
      @(negedge clk_8388);
      k++;
    end
    check("mid_reached_bit10", 128'(rise_cnt >= 14), 128'(1));
    ck_rst = 1'b0;
    #1;
    check("mid_rst_tck", 128'(tck_o), 128'(0));
    check("mid_rst_tms", 128'(tms_o), 128'(1));
    check("mid_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("mid_rst_cmd_ready", 128'(cmd_ready), 128'(0));
    repeat (3) @(negedge clk_8388);
    por_check("por2");

    do_cmd("dr_after", 2, 9, {$urandom, $urandom}, 0);

    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
